// File: rtl/cop_ram_arbiter_pkg.sv
// Shared widths and grant encoding for the copper RAM arbiter and its write FIFO.
package cop_ram_arbiter_pkg;

  localparam int COP_RAM_ADDR_WIDTH = 11;
  localparam int COP_RAM_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    GRANT_IDLE  = 2'd0,
    GRANT_READ  = 2'd1,
    GRANT_WRITE = 2'd2
  } grant_e;

endpackage

// File: rtl/cop_ram_write_fifo.sv
// Small {address,data} write FIFO for CPU writes to copper RAM; registered ready, no fall-through.
// With COP_RAM_FWD_EN defined, the read pointer and raw entries are exported for read forwarding.
module cop_ram_write_fifo
  import cop_ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = COP_RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = COP_RAM_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [ADDR_WIDTH-1:0]     push_address,
  input  logic [DATA_WIDTH-1:0]     push_data,
  input  logic                      pop,
  output logic [ADDR_WIDTH-1:0]     head_address,
  output logic [DATA_WIDTH-1:0]     head_data,
  output logic                      ready,
`ifdef COP_RAM_FWD_EN
  output logic [$clog2(DEPTH)-1:0]  rd_ptr,
  output logic [ADDR_WIDTH-1:0]     entry_address [DEPTH],
  output logic [DATA_WIDTH-1:0]     entry_data [DEPTH],
`endif
  output logic [$clog2(DEPTH):0]    level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_LEVEL = (PW+1)'(DEPTH);

`ifndef COP_RAM_FWD_EN
  logic [PW-1:0]         rd_ptr;
  logic [ADDR_WIDTH-1:0] entry_address [DEPTH];
  logic [DATA_WIDTH-1:0] entry_data [DEPTH];
`endif
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   level_next;

  // NOTE: entry storage is deliberately not reset; level and pointers decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_address[wr_ptr] <= push_address;
      entry_data[wr_ptr]    <= push_data;
    end
  end

  always_comb level_next = level + (PW+1)'(push) - (PW+1)'(pop);

  // ready resets high; the top masks it while reset is asserted.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ready  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_next;
      ready <= (level_next < FULL_LEVEL);
    end
  end

  assign head_address = entry_address[rd_ptr];
  assign head_data    = entry_data[rd_ptr];

endmodule

// File: rtl/cop_ram_arbiter.sv
// Shares the single-port copper RAM between buffered CPU writes and prioritised copper reads.
// Define COP_RAM_FWD_EN to forward still-buffered write data to matching copper reads.
module cop_ram_arbiter
  import cop_ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = COP_RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH   = COP_RAM_DATA_WIDTH,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cpu_write_en,
  input  logic [ADDR_WIDTH-1:0]         cpu_write_address,
  input  logic [DATA_WIDTH-1:0]         cpu_write_data,
  output logic                          cpu_write_ready,
  input  logic                          cop_read_en,
  input  logic [ADDR_WIDTH-1:0]         cop_read_address,
  output logic                          cop_read_ready,
  output logic [DATA_WIDTH-1:0]         cop_read_data,
  output logic                          cop_read_valid,
  output logic [ADDR_WIDTH-1:0]         ram_address,
  output logic                          ram_we,
  output logic [DATA_WIDTH-1:0]         ram_write_data,
  input  logic [DATA_WIDTH-1:0]         ram_read_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  grant_e                grant;
  logic                  fifo_ready, fifo_empty, push, pop, force_write, read_valid_q;
  logic [SW-1:0]         starve_q, starve_next;
  logic [ADDR_WIDTH-1:0] head_address, last_address_q;
  logic [DATA_WIDTH-1:0] head_data;

`ifdef COP_RAM_FWD_EN
  logic [PW-1:0]         rd_ptr;
  logic [ADDR_WIDTH-1:0] entry_address [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] entry_data [FIFO_DEPTH];
  logic                  fwd_hit, fwd_hit_q;
  logic [DATA_WIDTH-1:0] fwd_data, fwd_data_q;
`endif

  cop_ram_write_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_write_fifo (
    .clk           (clk),
    .reset         (reset),
    .push          (push),
    .push_address  (cpu_write_address),
    .push_data     (cpu_write_data),
    .pop           (pop),
    .head_address  (head_address),
    .head_data     (head_data),
    .ready         (fifo_ready),
`ifdef COP_RAM_FWD_EN
    .rd_ptr        (rd_ptr),
    .entry_address (entry_address),
    .entry_data    (entry_data),
`endif
    .level         (fifo_level)
  );

  assign cpu_write_ready = fifo_ready & ~reset;
  assign push            = cpu_write_en & cpu_write_ready;
  assign pop             = (grant == GRANT_WRITE);
  assign fifo_empty      = (fifo_level == '0);
  assign force_write     = (starve_q == STARVE_MAX) && !fifo_empty;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    grant = GRANT_IDLE;
    if (!reset) begin
      if (force_write)      grant = GRANT_WRITE;
      else if (cop_read_en) grant = GRANT_READ;
      else if (!fifo_empty) grant = GRANT_WRITE;
    end
  end

  always_comb begin
    starve_next = starve_q;
    if (grant == GRANT_WRITE || fifo_empty)
      starve_next = '0;
    else if (grant == GRANT_READ && starve_q != STARVE_MAX)
      starve_next = starve_q + 1'b1;
  end

  always_comb begin
    ram_address    = last_address_q;
    ram_we         = 1'b0;
    ram_write_data = head_data;
    cop_read_ready = 1'b0;
    case (grant)
      GRANT_READ: begin
        ram_address    = cop_read_address;
        cop_read_ready = 1'b1;
      end
      GRANT_WRITE: begin
        ram_address = head_address;
        ram_we      = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments; the combinational blocks above use blocking.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q       <= '0;
      read_valid_q   <= 1'b0;
      last_address_q <= '0;
    end else begin
      starve_q       <= starve_next;
      read_valid_q   <= (grant == GRANT_READ);
      last_address_q <= ram_address;
    end
  end

  assign cop_read_valid = read_valid_q;

`ifdef COP_RAM_FWD_EN
  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if ((PW+1)'(i) < fifo_level &&
          entry_address[rd_ptr + PW'(i)] == cop_read_address) begin
        fwd_hit  = 1'b1;
        fwd_data = entry_data[rd_ptr + PW'(i)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else if (grant == GRANT_READ) begin
      fwd_hit_q  <= fwd_hit;
      fwd_data_q <= fwd_data;
    end
  end

  assign cop_read_data = !read_valid_q ? '0 : (fwd_hit_q ? fwd_data_q : ram_read_data);
`else
  assign cop_read_data = read_valid_q ? ram_read_data : '0;
`endif

endmodule

// File: tb/tb_cop_ram_arbiter.sv
// Self-checking bench for cop_ram_arbiter: vector table plus directed multi-cycle sequences.
// Expected forwarding data follows COP_RAM_FWD_EN when the bench is built with it.
module tb_cop_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_write_en;
  logic [10:0] cpu_write_address;
  logic [15:0] cpu_write_data;
  logic        cpu_write_ready;
  logic        cop_read_en;
  logic [10:0] cop_read_address;
  logic        cop_read_ready;
  logic [15:0] cop_read_data;
  logic        cop_read_valid;
  logic [10:0] ram_address;
  logic        ram_we;
  logic [15:0] ram_write_data;
  logic [15:0] ram_read_data;
  logic [2:0]  fifo_level;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cop_ram_arbiter dut (
    .clk               (clk),
    .reset             (reset),
    .cpu_write_en      (cpu_write_en),
    .cpu_write_address (cpu_write_address),
    .cpu_write_data    (cpu_write_data),
    .cpu_write_ready   (cpu_write_ready),
    .cop_read_en       (cop_read_en),
    .cop_read_address  (cop_read_address),
    .cop_read_ready    (cop_read_ready),
    .cop_read_data     (cop_read_data),
    .cop_read_valid    (cop_read_valid),
    .ram_address       (ram_address),
    .ram_we            (ram_we),
    .ram_write_data    (ram_write_data),
    .ram_read_data     (ram_read_data),
    .fifo_level        (fifo_level)
  );

  // Copper RAM model: single port, registered read data.
  logic [15:0] mem [0:2047] = '{default: 16'h0000};
  logic        preload = 1'b0;

  always @(posedge clk) begin
    if (preload) begin
      mem[11'h005] <= 16'h1234;
      mem[11'h010] <= 16'h0F0F;
    end else if (ram_we) begin
      mem[ram_address] <= ram_write_data;
    end
    ram_read_data <= mem[ram_address];
  end

`ifdef COP_RAM_FWD_EN
  localparam logic [15:0] FWD_EXPECT = 16'hBEEF;
`else
  localparam logic [15:0] FWD_EXPECT = 16'h0F0F;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [10:0] waddr;
    logic [15:0] wdata;
    logic        re;
    logic [10:0] raddr;
    logic        x_ram_we;
    logic [10:0] x_ram_addr;
    logic [15:0] x_ram_wdata;
    logic        x_ready;
    logic [2:0]  x_level;
    logic        x_rd_ready;
    logic        x_valid;
    logic [15:0] x_rdata;
  } vec_t;

  vec_t vecs [8];

  logic [10:0] fill_addr [5];
  logic [15:0] fill_data [5];

  initial begin
    // Back-to-back writes, then a single read of address 0x005.
    vecs[0] = '{1'b1, 11'h000, 16'hA000, 1'b0, 11'h000, 1'b0, 11'h000, 16'h0000, 1'b1, 3'd0, 1'b0, 1'b0, 16'h0000};
    vecs[1] = '{1'b1, 11'h001, 16'hA001, 1'b0, 11'h000, 1'b1, 11'h000, 16'hA000, 1'b1, 3'd1, 1'b0, 1'b0, 16'h0000};
    vecs[2] = '{1'b1, 11'h002, 16'hA002, 1'b0, 11'h000, 1'b1, 11'h001, 16'hA001, 1'b1, 3'd1, 1'b0, 1'b0, 16'h0000};
    vecs[3] = '{1'b1, 11'h003, 16'hA003, 1'b0, 11'h000, 1'b1, 11'h002, 16'hA002, 1'b1, 3'd1, 1'b0, 1'b0, 16'h0000};
    vecs[4] = '{1'b0, 11'h000, 16'h0000, 1'b0, 11'h000, 1'b1, 11'h003, 16'hA003, 1'b1, 3'd1, 1'b0, 1'b0, 16'h0000};
    vecs[5] = '{1'b0, 11'h000, 16'h0000, 1'b0, 11'h000, 1'b0, 11'h003, 16'h0000, 1'b1, 3'd0, 1'b0, 1'b0, 16'h0000};
    vecs[6] = '{1'b0, 11'h000, 16'h0000, 1'b1, 11'h005, 1'b0, 11'h005, 16'h0000, 1'b1, 3'd0, 1'b1, 1'b0, 16'h0000};
    vecs[7] = '{1'b0, 11'h000, 16'h0000, 1'b0, 11'h000, 1'b0, 11'h005, 16'h0000, 1'b1, 3'd0, 1'b0, 1'b1, 16'h1234};

    fill_addr = '{11'h050, 11'h051, 11'h052, 11'h020, 11'h020};
    fill_data = '{16'h1110, 16'h2220, 16'h3330, 16'h4440, 16'h5550};

    // ---- Reset state (read request held high to show it is not granted)
    reset = 1'b1; preload = 1'b1;
    cpu_write_en = 1'b0; cpu_write_address = '0; cpu_write_data = '0;
    cop_read_en = 1'b1; cop_read_address = 11'h005;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready",    32'(cpu_write_ready), 32'd0);
    check("reset_ram_we",   32'(ram_we),          32'd0);
    check("reset_valid",    32'(cop_read_valid),  32'd0);
    check("reset_rdata",    32'(cop_read_data),   32'd0);
    check("reset_level",    32'(fifo_level),      32'd0);
    check("reset_rd_ready", 32'(cop_read_ready),  32'd0);
    next_cycle();
    reset = 1'b0; preload = 1'b0; cop_read_en = 1'b0;

    // ---- Vector table
    for (int i = 0; i < 8; i++) begin
      cpu_write_en = vecs[i].we; cpu_write_address = vecs[i].waddr; cpu_write_data = vecs[i].wdata;
      cop_read_en = vecs[i].re; cop_read_address = vecs[i].raddr;
      @(negedge clk);
      check($sformatf("vec%0d_ram_we", i),   32'(ram_we),         32'(vecs[i].x_ram_we));
      check($sformatf("vec%0d_ram_addr", i), 32'(ram_address),    32'(vecs[i].x_ram_addr));
      if (vecs[i].x_ram_we)
        check($sformatf("vec%0d_ram_wdata", i), 32'(ram_write_data), 32'(vecs[i].x_ram_wdata));
      check($sformatf("vec%0d_ready", i),    32'(cpu_write_ready), 32'(vecs[i].x_ready));
      check($sformatf("vec%0d_level", i),    32'(fifo_level),      32'(vecs[i].x_level));
      check($sformatf("vec%0d_rd_ready", i), 32'(cop_read_ready),  32'(vecs[i].x_rd_ready));
      check($sformatf("vec%0d_valid", i),    32'(cop_read_valid),  32'(vecs[i].x_valid));
      if (vecs[i].x_valid)
        check($sformatf("vec%0d_rdata", i), 32'(cop_read_data), 32'(vecs[i].x_rdata));
      next_cycle();
    end
    cpu_write_en = 1'b0; cop_read_en = 1'b0;
    for (int a = 0; a < 4; a++)
      check($sformatf("b2b_mem%0d", a), 32'(mem[a]), 32'h0000A000 + 32'(a));

    // ---- Starvation: continuous reads, two buffered writes
    cop_read_en = 1'b1; cop_read_address = 11'h100;
    for (int c = 0; c < 21; c++) begin
      logic       x_rdy;
      logic [2:0] x_lvl;
      cpu_write_en      = (c < 2);
      cpu_write_address = (c == 0) ? 11'h040 : 11'h041;
      cpu_write_data    = (c == 0) ? 16'h5550 : 16'h5551;
      x_rdy = !(c == 9 || c == 18);
      x_lvl = (c == 0) ? 3'd0 : (c == 1) ? 3'd1 : (c <= 9) ? 3'd2 : (c <= 18) ? 3'd1 : 3'd0;
      @(negedge clk);
      check($sformatf("starve_c%0d_rd_ready", c), 32'(cop_read_ready), 32'(x_rdy));
      check($sformatf("starve_c%0d_ram_we", c),   32'(ram_we),         32'(!x_rdy));
      check($sformatf("starve_c%0d_level", c),    32'(fifo_level),     32'(x_lvl));
      check($sformatf("starve_c%0d_valid", c),    32'(cop_read_valid), 32'(c != 0 && c != 10 && c != 19));
      if (c == 9)  check("starve_w0_addr", 32'(ram_address), 32'h040);
      if (c == 18) check("starve_w1_addr", 32'(ram_address), 32'h041);
      next_cycle();
    end
    cpu_write_en = 1'b0; cop_read_en = 1'b0;
    repeat (2) next_cycle();
    check("starve_mem40", 32'(mem[11'h040]), 32'h5550);
    check("starve_mem41", 32'(mem[11'h041]), 32'h5551);

    // ---- FIFO fill under continuous reads; CPU holds its request while not ready
    begin
      int idx = 0;
      cop_read_en = 1'b1; cop_read_address = 11'h101;
      for (int b = 0; b < 11; b++) begin
        cpu_write_en = (idx < 5);
        if (idx < 5) begin
          cpu_write_address = fill_addr[idx];
          cpu_write_data    = fill_data[idx];
        end
        @(negedge clk);
        check($sformatf("fill_b%0d_ready", b),    32'(cpu_write_ready), 32'((b < 4) || (b == 10)));
        check($sformatf("fill_b%0d_rd_ready", b), 32'(cop_read_ready),  32'(b != 9));
        if (cpu_write_en && cpu_write_ready) idx++;
        next_cycle();
      end
      check("fill_all_pushed", 32'(idx), 32'd5);
    end
    cpu_write_en = 1'b0; cop_read_en = 1'b0;
    repeat (8) next_cycle();
    @(negedge clk);
    check("fill_level_drained", 32'(fifo_level), 32'd0);
    check("fill_mem50", 32'(mem[11'h050]), 32'h1110);
    check("fill_mem51", 32'(mem[11'h051]), 32'h2220);
    check("fill_mem52", 32'(mem[11'h052]), 32'h3330);
    check("fill_mem20_last_wins", 32'(mem[11'h020]), 32'h5550);
    next_cycle();

    // ---- Forwarding: push 0x010=0xBEEF, read 0x010 in the next cycle
    cpu_write_en = 1'b1; cpu_write_address = 11'h010; cpu_write_data = 16'hBEEF;
    @(negedge clk);
    check("fwd_push_idle", 32'(ram_we), 32'd0);
    next_cycle();
    cpu_write_en = 1'b0; cop_read_en = 1'b1; cop_read_address = 11'h010;
    @(negedge clk);
    check("fwd_read_granted", 32'(cop_read_ready), 32'd1);
    check("fwd_level", 32'(fifo_level), 32'd1);
    next_cycle();
    cop_read_en = 1'b0;
    @(negedge clk);
    check("fwd_valid", 32'(cop_read_valid), 32'd1);
    check("fwd_data", 32'(cop_read_data), 32'(FWD_EXPECT));
    check("fwd_drain_we", 32'(ram_we), 32'd1);
    check("fwd_drain_addr", 32'(ram_address), 32'h010);
    next_cycle();
    cop_read_en = 1'b1;
    next_cycle();
    cop_read_en = 1'b0;
    @(negedge clk);
    check("fwd_reread_data", 32'(cop_read_data), 32'hBEEF);
    next_cycle();

    // ---- Reset with three writes buffered and a read in flight
    cop_read_en = 1'b1; cop_read_address = 11'h102;
    for (int r = 0; r < 3; r++) begin
      cpu_write_en = 1'b1; cpu_write_address = 11'h300 + 11'(r); cpu_write_data = 16'hD000 + 16'(r);
      next_cycle();
    end
    cpu_write_en = 1'b0;
    @(negedge clk);
    check("rst_pre_level", 32'(fifo_level), 32'd3);
    check("rst_pre_rd_ready", 32'(cop_read_ready), 32'd1);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    check("rst_hi_ram_we", 32'(ram_we), 32'd0);
    check("rst_hi_rd_ready", 32'(cop_read_ready), 32'd0);
    check("rst_hi_ready", 32'(cpu_write_ready), 32'd0);
    next_cycle();
    reset = 1'b0; cop_read_en = 1'b0;
    @(negedge clk);
    check("rst_post_level", 32'(fifo_level), 32'd0);
    check("rst_post_valid", 32'(cop_read_valid), 32'd0);
    check("rst_post_ram_we", 32'(ram_we), 32'd0);
    check("rst_post_ready", 32'(cpu_write_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      @(negedge clk);
      check($sformatf("rst_idle%0d_ram_we", k), 32'(ram_we), 32'd0);
    end
    for (int r = 0; r < 3; r++)
      check($sformatf("rst_mem%0d_untouched", r), 32'(mem[11'h300 + 11'(r)]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
